// File: rtl/param_shift_register.sv
// param_shift_register
//   Parametrised shift register with hold / shift-left / shift-right /
//   rotate-left modes, serial input, parallel load and a bit counter that
//   strobes Word_valid after every WIDTH active operations.
//   Intended as a serializer/deserializer stage between word-wide
//   producers and single-bit serial links.
//
//   Optional feature: define PARAM_SHIFT_PARITY_EN to add a registered
//   Parity output (XOR reduction of the register value written each edge).
//
//   All state changes on the rising edge of Clk; Rst is synchronous and
//   active-high. Every output is registered.
module param_shift_register #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Load,
   input  logic             En,
   input  logic [1:0]       Mode,
   input  logic             Din,
   input  logic [WIDTH-1:0] A,
   output logic             Dout,
   output logic [WIDTH-1:0] register,
   output logic [CNT_W-1:0] Count,
`ifdef PARAM_SHIFT_PARITY_EN
   output logic             Parity,
`endif
   output logic             Word_valid
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHL  = 2'b01,
      MODE_SHR  = 2'b10,
      MODE_ROL  = 2'b11
   } mode_t;

   // Count value on which the next active operation completes a word.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mode_t            mode;
   logic             active;
   logic [WIDTH-1:0] reg_q,  reg_nxt;
   logic             dout_q, dout_nxt;
   logic [CNT_W-1:0] cnt_q,  cnt_nxt;
   logic             wv_q,   wv_nxt;
   logic             upd;

   assign mode   = mode_t'(Mode);
   // An operation happens only with En set and a non-hold mode; Load overrides it.
   assign active = En && (mode != MODE_HOLD);
   assign upd    = Load || active;

   // Next-state selection: Load beats an active operation; otherwise hold.
   always_comb begin
      reg_nxt  = reg_q;
      dout_nxt = dout_q;
      cnt_nxt  = cnt_q;
      wv_nxt   = 1'b0;
      if (Load) begin
         reg_nxt  = A;
         dout_nxt = 1'b0;
         cnt_nxt  = '0;
      end else if (active) begin
         case (mode)
            MODE_SHL: begin
               reg_nxt  = {reg_q[WIDTH-2:0], Din};
               dout_nxt = reg_q[WIDTH-1];
            end
            MODE_SHR: begin
               reg_nxt  = {Din, reg_q[WIDTH-1:1]};
               dout_nxt = reg_q[0];
            end
            MODE_ROL: begin
               reg_nxt  = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
               dout_nxt = reg_q[WIDTH-1];
            end
            default: begin
               reg_nxt  = reg_q;
               dout_nxt = dout_q;
            end
         endcase
         if (cnt_q == CNT_LAST) begin
            cnt_nxt = '0;
            wv_nxt  = 1'b1;
         end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
         end
      end
   end

   // State register with synchronous reset; reset also drops any pending strobe.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         reg_q  <= '0;
         dout_q <= 1'b0;
         cnt_q  <= '0;
         wv_q   <= 1'b0;
      end else begin
         reg_q  <= reg_nxt;
         dout_q <= dout_nxt;
         cnt_q  <= cnt_nxt;
         wv_q   <= wv_nxt;
      end
   end

`ifdef PARAM_SHIFT_PARITY_EN
   logic parity_q;

   // Parity tracks the value written on load/shift/rotate and holds otherwise.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         parity_q <= 1'b0;
      end else if (upd) begin
         parity_q <= ^reg_nxt;
      end
   end

   assign Parity = parity_q;
`else
   logic unused_upd;
   assign unused_upd = upd;
`endif

   assign register   = reg_q;
   assign Dout       = dout_q;
   assign Count      = cnt_q;
   assign Word_valid = wv_q;

endmodule
